// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back stage.
package wb_pkg;

  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned MEM_SIZE_W = 2;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [MEM_SIZE_W-1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

endpackage

// File: rtl/wb_load_align.sv
// Load-data lane select and sign/zero extension (combinational).
// Misaligned halfwords use the lane picked by addr[1] alone.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        addr_i,
  input  mem_size_e         size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = data_i[{addr_i, 3'b000} +: 8];
    half_c = data_i[{addr_i[1], 4'b0000} +: 16];
    data_o = data_i;
    case (size_i)
      SZ_B:    data_o = unsigned_i ? DATA_W'(byte_c) : {{(DATA_W-8){byte_c[7]}}, byte_c};
      SZ_H:    data_o = unsigned_i ? DATA_W'(half_c) : {{(DATA_W-16){half_c[15]}}, half_c};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, result select, register-file write port, hold register and retire counter.
// Define WB_LOAD_EXT_EN to align and extend load data by size/signedness.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_waddr,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [1:0]            in_mem_size,
  input  logic                  in_mem_unsigned,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  hold_valid,
  output logic [REG_ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0]     hold_data,
  output logic [CNT_W-1:0]      retire_count
);

  logic                  valid_q, valid_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  wb_sel_e               wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     pc4_q, pc4_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic                  done_q, done_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [REG_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]     hold_data_q, hold_data_d;
  logic [CNT_W-1:0]      retire_q, retire_d;
  logic [DATA_W-1:0]     load_data_c;

`ifdef WB_LOAD_EXT_EN
  mem_size_e mem_size_q, mem_size_d;
  logic      mem_unsigned_q, mem_unsigned_d;

  always_comb begin
    mem_size_d     = mem_size_q;
    mem_unsigned_d = mem_unsigned_q;
    if (!stall) begin
      mem_size_d     = mem_size_e'(in_mem_size);
      mem_unsigned_d = in_mem_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_size_q     <= SZ_B;
      mem_unsigned_q <= 1'b0;
    end else begin
      mem_size_q     <= mem_size_d;
      mem_unsigned_q <= mem_unsigned_d;
    end
  end

  // Lane offset comes from the captured effective address in the ALU result.
  wb_load_align #(.DATA_W(DATA_W)) u_load_align (
    .data_i     (rdata_q),
    .addr_i     (alu_q[1:0]),
    .size_i     (mem_size_q),
    .unsigned_i (mem_unsigned_q),
    .data_o     (load_data_c)
  );
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{in_mem_size, in_mem_unsigned};
  assign load_data_c      = rdata_q;
`endif

  always_comb begin
    rf_wdata = alu_q;
    case (wb_sel_q)
      WB_ALU:  rf_wdata = alu_q;
      WB_MEM:  rf_wdata = load_data_c;
      WB_PC4:  rf_wdata = pc4_q;
      WB_IMM:  rf_wdata = imm_q;
      default: rf_wdata = alu_q;
    endcase
  end

  assign rf_waddr = waddr_q;
  assign rf_we    = valid_q & regwrite_q & (waddr_q != '0) & ~done_q;

  // done_q makes a stalled entry write exactly once; flush beats stall.
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    waddr_d      = waddr_q;
    wb_sel_d     = wb_sel_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    pc4_d        = pc4_q;
    imm_d        = imm_q;
    done_d       = done_q;
    hold_valid_d = 1'b0;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    retire_d     = retire_q + CNT_W'(valid_q & ~stall);

    if (!stall) begin
      valid_d    = in_valid;
      regwrite_d = in_regwrite;
      waddr_d    = in_waddr;
      wb_sel_d   = wb_sel_e'(in_wb_sel);
      alu_d      = in_alu_result;
      rdata_d    = in_read_data;
      pc4_d      = in_pc_plus4;
      imm_d      = in_imm;
      done_d     = 1'b0;
    end else if (rf_we) begin
      done_d = 1'b1;
    end

    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    if (rf_we) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = rf_waddr;
      hold_data_d  = rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      waddr_q      <= '0;
      wb_sel_q     <= WB_ALU;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
      imm_q        <= '0;
      done_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      retire_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      waddr_q      <= waddr_d;
      wb_sel_q     <= wb_sel_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      pc4_q        <= pc4_d;
      imm_q        <= imm_d;
      done_q       <= done_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      retire_q     <= retire_d;
    end
  end

  assign hold_valid   = hold_valid_q;
  assign hold_addr    = hold_addr_q;
  assign hold_data    = hold_data_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage built with a 4-bit retire counter.
module tb_wb_stage;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall, flush, in_valid, in_regwrite, in_mem_unsigned;
  logic [REG_ADDR_W-1:0] in_waddr;
  logic [1:0]            in_wb_sel, in_mem_size;
  logic [DATA_W-1:0]     in_alu_result, in_read_data, in_pc_plus4, in_imm;
  logic                  rf_we, hold_valid;
  logic [REG_ADDR_W-1:0] rf_waddr, hold_addr;
  logic [DATA_W-1:0]     rf_wdata, hold_data;
  logic [CNT_W-1:0]      retire_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_regwrite     (in_regwrite),
    .in_waddr        (in_waddr),
    .in_wb_sel       (in_wb_sel),
    .in_alu_result   (in_alu_result),
    .in_read_data    (in_read_data),
    .in_pc_plus4     (in_pc_plus4),
    .in_imm          (in_imm),
    .in_mem_size     (in_mem_size),
    .in_mem_unsigned (in_mem_unsigned),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .hold_valid      (hold_valid),
    .hold_addr       (hold_addr),
    .hold_data       (hold_data),
    .retire_count    (retire_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] wa, input logic [1:0] sel);
    in_valid    = v;
    in_regwrite = rw;
    in_waddr    = wa;
    in_wb_sel   = sel;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0);
    in_alu_result = '0; in_read_data = '0; in_pc_plus4 = '0; in_imm = '0;
    in_mem_size = 2'd0; in_mem_unsigned = 1'b0;
    #12;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_hold_valid", 64'(hold_valid), 64'd0);
    chk("rst_hold_addr", 64'(hold_addr), 64'd0);
    chk("rst_hold_data", 64'(hold_data), 64'd0);
    chk("rst_retire", 64'(retire_count), 64'd0);
    rst_n = 1'b1;

    // Basic ALU write, then hold register and retire
    drive(1'b1, 1'b1, 5'd5, 2'd0); in_alu_result = 32'h1234;
    step();
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd5);
    chk("t1_wdata", 64'(rf_wdata), 64'h1234);
    chk("t1_retire0", 64'(retire_count), 64'd0);
    drive(1'b0, 1'b0, 5'd0, 2'd0);
    step();
    chk("t1_hold_valid", 64'(hold_valid), 64'd1);
    chk("t1_hold_addr", 64'(hold_addr), 64'd5);
    chk("t1_hold_data", 64'(hold_data), 64'h1234);
    chk("t1_retire1", 64'(retire_count), 64'd1);
    chk("t1_we_off", 64'(rf_we), 64'd0);

    // x0 never written but still retires; PC+4 select
    drive(1'b1, 1'b1, 5'd0, 2'd0); in_alu_result = 32'h99;
    step();
    chk("t2_x0_we", 64'(rf_we), 64'd0);
    chk("t2_retire1", 64'(retire_count), 64'd1);
    drive(1'b1, 1'b1, 5'd31, 2'd2); in_pc_plus4 = 32'h40;
    step();
    chk("t2_pc4_we", 64'(rf_we), 64'd1);
    chk("t2_pc4_wdata", 64'(rf_wdata), 64'h40);
    chk("t2_retire2", 64'(retire_count), 64'd2);
    chk("t2_hold_off", 64'(hold_valid), 64'd0);
    drive(1'b0, 1'b0, 5'd0, 2'd0);
    step();
    chk("t2_retire3", 64'(retire_count), 64'd3);
    chk("t2_hold_addr", 64'(hold_addr), 64'd31);
    chk("t2_hold_data", 64'(hold_data), 64'h40);

    // Stall for three cycles: single write, retire after release
    drive(1'b1, 1'b1, 5'd7, 2'd3); in_imm = 32'hABC0_0000;
    step();
    chk("t3_imm_wdata", 64'(rf_wdata), 64'hABC0_0000);
    drive(1'b0, 1'b0, 5'd0, 2'd0); stall = 1'b1;
    #1;
    chk("t3_stall1_we", 64'(rf_we), 64'd1);
    step();
    chk("t3_stall2_we", 64'(rf_we), 64'd0);
    chk("t3_stall2_retire", 64'(retire_count), 64'd3);
    chk("t3_stall2_hold", 64'(hold_valid), 64'd1);
    chk("t3_stall2_haddr", 64'(hold_addr), 64'd7);
    step();
    chk("t3_stall3_we", 64'(rf_we), 64'd0);
    chk("t3_stall3_hold", 64'(hold_valid), 64'd0);
    chk("t3_stall3_retire", 64'(retire_count), 64'd3);
    stall = 1'b0;
    step();
    chk("t3_release_retire", 64'(retire_count), 64'd4);
    chk("t3_release_we", 64'(rf_we), 64'd0);

    // Stall+flush on a fresh capture
    drive(1'b1, 1'b1, 5'd9, 2'd0); stall = 1'b1; flush = 1'b1;
    step();
    chk("t4_flush_we", 64'(rf_we), 64'd0);
    chk("t4_flush_retire", 64'(retire_count), 64'd4);
    drive(1'b0, 1'b0, 5'd0, 2'd0); stall = 1'b0; flush = 1'b0;
    step();
    chk("t4_after_retire", 64'(retire_count), 64'd4);
    // Stall+flush drops a valid held entry without retiring it
    drive(1'b1, 1'b1, 5'd10, 2'd0); in_alu_result = 32'h77;
    step();
    chk("t4b_we", 64'(rf_we), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0); stall = 1'b1; flush = 1'b1;
    step();
    chk("t4b_flush_we", 64'(rf_we), 64'd0);
    chk("t4b_flush_retire", 64'(retire_count), 64'd4);
    chk("t4b_hold", 64'(hold_data), 64'h77);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("t4b_after_retire", 64'(retire_count), 64'd4);

    // Load data selection
    drive(1'b1, 1'b1, 5'd3, 2'd1);
    in_read_data = 32'h80FF_7F01; in_alu_result = 32'd3; in_mem_size = 2'd0; in_mem_unsigned = 1'b0;
    step();
`ifdef WB_LOAD_EXT_EN
    chk("t5_byte_s", 64'(rf_wdata), 64'hFFFF_FF80);
`else
    chk("t5_raw_a", 64'(rf_wdata), 64'h80FF_7F01);
`endif
    in_mem_unsigned = 1'b1;
    step();
`ifdef WB_LOAD_EXT_EN
    chk("t5_byte_u", 64'(rf_wdata), 64'h0000_0080);
`else
    chk("t5_raw_b", 64'(rf_wdata), 64'h80FF_7F01);
`endif
    in_alu_result = 32'd2; in_mem_size = 2'd1; in_mem_unsigned = 1'b0;
    step();
`ifdef WB_LOAD_EXT_EN
    chk("t5_half_s", 64'(rf_wdata), 64'hFFFF_80FF);
`else
    chk("t5_raw_c", 64'(rf_wdata), 64'h80FF_7F01);
`endif
    in_alu_result = 32'd0; in_mem_size = 2'd2;
    step();
    chk("t5_word", 64'(rf_wdata), 64'h80FF_7F01);
    drive(1'b0, 1'b0, 5'd0, 2'd0);
    step();
    chk("t5_retire", 64'(retire_count), 64'd8);

    // Counter wrap with non-writing instructions
    drive(1'b1, 1'b0, 5'd4, 2'd0);
    for (int i = 0; i < 8; i++) step();
    chk("t6_max", 64'(retire_count), 64'd15);
    chk("t6_no_we", 64'(rf_we), 64'd0);
    step();
    chk("t6_wrap", 64'(retire_count), 64'd0);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 1'b1, 5'd12, 2'd0); in_alu_result = 32'h55;
    step();
    chk("t7_pre_we", 64'(rf_we), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0); stall = 1'b1;
    step();
    chk("t7_pre_hold", 64'(hold_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_we", 64'(rf_we), 64'd0);
    chk("t7_waddr", 64'(rf_waddr), 64'd0);
    chk("t7_wdata", 64'(rf_wdata), 64'd0);
    chk("t7_hold_valid", 64'(hold_valid), 64'd0);
    chk("t7_hold_addr", 64'(hold_addr), 64'd0);
    chk("t7_hold_data", 64'(hold_data), 64'd0);
    chk("t7_retire", 64'(retire_count), 64'd0);
    step();
    chk("t7_held_we", 64'(rf_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
